// File: rtl/ems_pkg.sv
// EMS page mapper shared definitions: I/O base and frame tables, register entry type,
// window-index helper. No ports (package).
// Entries are stored at the widest page size; narrower configurations keep upper page bits zero.
package ems_pkg;

  localparam int MAX_PAGES     = 4;
  // Bit 7 of the data bus carries the enable flag, so a page number is at most 7 bits.
  localparam int PAGE_BITS_MAX = 7;

  // Indexed by io_base_select: 0x208, 0x218, 0x258, 0x268.
  localparam logic [3:0][15:0] IO_BASE_TABLE = {16'h0268, 16'h0258, 16'h0218, 16'h0208};

  // Indexed by frame_select: top address nibble of the 64 KB frame (C, D, E, A).
  localparam logic [3:0][3:0] FRAME_NIBBLE_TABLE = {4'hA, 4'hE, 4'hD, 4'hC};

  typedef struct packed {
    logic                     en;
    logic [PAGE_BITS_MAX-1:0] page;
  } ems_entry_t;

  // Window index from address[15:14]; fewer windows use fewer low bits.
  function automatic logic [1:0] idx_of(input logic [1:0] window, input int num_pages);
    logic [1:0] idx;
    if (num_pages >= 4) begin
      idx = window;
    end else if (num_pages == 2) begin
      idx = {1'b0, window[0]};
    end else begin
      idx = 2'b00;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ems_wait_counter.sv
// Wait-state generator: holds ready low for WAIT_STATES clocks after a mapped memory strobe falls.
// Ports: clock, reset (sync, active high), memory_read_n/memory_write_n strobes,
//        hit (combinational mapped hit), ready (high when no wait is pending).
module ems_wait_counter #(
  parameter int WAIT_STATES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic memory_read_n,
  input  logic memory_write_n,
  input  logic hit,
  output logic ready
);

  logic       read_n_q;
  logic       write_n_q;
  logic [3:0] count;
  logic       start;

  // A command starts on the first low sample of either strobe while the address maps.
  assign start = hit & ((read_n_q & ~memory_read_n) | (write_n_q & ~memory_write_n));

  always_ff @(posedge clock) begin
    if (reset) begin
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      count     <= 4'd0;
    end else begin
      read_n_q  <= memory_read_n;
      write_n_q <= memory_write_n;
      // A new mapped command reloads even while a previous wait is still running.
      if (start) begin
        count <= 4'(WAIT_STATES);
      end else if (count != 4'd0) begin
        count <= count - 4'd1;
      end
    end
  end

  assign ready = (count == 4'd0);

endmodule

// File: rtl/ems_page_mapper.sv
// EMS page mapper: NUM_PAGES page registers behind an I/O port block, translating 16 KB
// upper-memory windows onto PAGE_BITS-wide extended RAM pages with a 1-cycle registered result.
// Ports: clock/reset, enable, io_base_select, frame_select, address, internal_data_bus,
//        I/O and memory strobes, address_enable_n (low = DMA); outputs data_bus_out(_valid),
//        mapped_address, mapped_hit, ready.
module ems_page_mapper
  import ems_pkg::*;
#(
  parameter int NUM_PAGES   = 4,
  parameter int PAGE_BITS   = 7,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            io_base_select,
  input  logic [1:0]            frame_select,
  input  logic [19:0]           address,
  input  logic [7:0]            internal_data_bus,
  input  logic                  io_read_n,
  input  logic                  io_write_n,
  input  logic                  memory_read_n,
  input  logic                  memory_write_n,
  input  logic                  address_enable_n,
  output logic [7:0]            data_bus_out,
  output logic                  data_bus_out_valid,
  output logic [PAGE_BITS+13:0] mapped_address,
  output logic                  mapped_hit,
  output logic                  ready
);

  // Page numbers are truncated to PAGE_BITS on write, so readback is zero-padded.
  localparam logic [PAGE_BITS_MAX-1:0] PAGE_MASK = PAGE_BITS_MAX'((1 << PAGE_BITS) - 1);

  // Slots at or above NUM_PAGES are never written and stay at their reset value.
  ems_entry_t  entries [MAX_PAGES];

  logic        io_write_n_q;
  logic [15:0] io_base;
  logic [15:0] port_offset;
  logic [1:0]  port_idx;
  logic        port_hit;
  logic        frame_hit;
  logic [1:0]  idx;
  logic        hit_comb;
  logic        write_commit;

  // Port decode: an address below the base wraps to a large offset and misses.
  assign io_base     = IO_BASE_TABLE[io_base_select];
  assign port_offset = address[15:0] - io_base;
  assign port_idx    = port_offset[1:0];
  assign port_hit    = enable & address_enable_n & (address[19:16] == 4'h0)
                     & ({16'h0000, port_offset} < 32'(NUM_PAGES));

  assign frame_hit = (address[19:16] == FRAME_NIBBLE_TABLE[frame_select])
                   & ({30'h0, address[15:14]} < 32'(NUM_PAGES));
  assign idx       = idx_of(address[15:14], NUM_PAGES);
  assign hit_comb  = enable & frame_hit & entries[idx].en;

  // One commit per strobe: only the sample where io_write_n first goes low counts.
  assign write_commit = io_write_n_q & ~io_write_n & port_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_write_n_q   <= 1'b1;
      mapped_hit     <= 1'b0;
      mapped_address <= '0;
      for (int i = 0; i < MAX_PAGES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      io_write_n_q <= io_write_n;
      if (write_commit) begin
        entries[port_idx].en   <= internal_data_bus[7];
        entries[port_idx].page <= internal_data_bus[PAGE_BITS_MAX-1:0] & PAGE_MASK;
      end
      // Reads the pre-write entry, so a same-cycle write shows up one cycle later.
      mapped_hit     <= hit_comb;
      mapped_address <= {entries[idx].page[PAGE_BITS-1:0], address[13:0]};
    end
  end

  always_comb begin
    data_bus_out       = 8'h00;
    data_bus_out_valid = 1'b0;
    if (port_hit && !io_read_n) begin
      data_bus_out       = entries[port_idx];
      data_bus_out_valid = 1'b1;
    end
  end

  ems_wait_counter #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_counter (
    .clock         (clock),
    .reset         (reset),
    .memory_read_n (memory_read_n),
    .memory_write_n(memory_write_n),
    .hit           (hit_comb),
    .ready         (ready)
  );

endmodule

// File: tb/tb_ems_page_mapper.sv
// Bench for ems_page_mapper: three configurations share one stimulus stream and are each
// compared every cycle against an arithmetic reference model kept here.
// Ports: none.
module tb_ems_page_mapper;

  localparam int NDUT = 3;
  localparam int NP [NDUT] = '{4, 2, 1};
  localparam int PB [NDUT] = '{7, 5, 6};
  localparam int WS [NDUT] = '{3, 0, 2};

  logic        clock;
  logic        reset;
  logic        enable;
  logic [1:0]  io_base_select;
  logic [1:0]  frame_select;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        io_read_n;
  logic        io_write_n;
  logic        memory_read_n;
  logic        memory_write_n;
  logic        address_enable_n;

  logic [7:0]  dbo [NDUT];
  logic        dbv [NDUT];
  logic        mh  [NDUT];
  logic        rdy [NDUT];
  logic [20:0] ma0;
  logic [18:0] ma1;
  logic [19:0] ma2;
  logic [31:0] ma_w [NDUT];

  assign ma_w[0] = {11'h0, ma0};
  assign ma_w[1] = {13'h0, ma1};
  assign ma_w[2] = {12'h0, ma2};

  ems_page_mapper #(.NUM_PAGES(4), .PAGE_BITS(7), .WAIT_STATES(3)) u_dut0 (
    .clock(clock), .reset(reset), .enable(enable), .io_base_select(io_base_select),
    .frame_select(frame_select), .address(address), .internal_data_bus(internal_data_bus),
    .io_read_n(io_read_n), .io_write_n(io_write_n), .memory_read_n(memory_read_n),
    .memory_write_n(memory_write_n), .address_enable_n(address_enable_n),
    .data_bus_out(dbo[0]), .data_bus_out_valid(dbv[0]), .mapped_address(ma0),
    .mapped_hit(mh[0]), .ready(rdy[0]));

  ems_page_mapper #(.NUM_PAGES(2), .PAGE_BITS(5), .WAIT_STATES(0)) u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .io_base_select(io_base_select),
    .frame_select(frame_select), .address(address), .internal_data_bus(internal_data_bus),
    .io_read_n(io_read_n), .io_write_n(io_write_n), .memory_read_n(memory_read_n),
    .memory_write_n(memory_write_n), .address_enable_n(address_enable_n),
    .data_bus_out(dbo[1]), .data_bus_out_valid(dbv[1]), .mapped_address(ma1),
    .mapped_hit(mh[1]), .ready(rdy[1]));

  ems_page_mapper #(.NUM_PAGES(1), .PAGE_BITS(6), .WAIT_STATES(2)) u_dut2 (
    .clock(clock), .reset(reset), .enable(enable), .io_base_select(io_base_select),
    .frame_select(frame_select), .address(address), .internal_data_bus(internal_data_bus),
    .io_read_n(io_read_n), .io_write_n(io_write_n), .memory_read_n(memory_read_n),
    .memory_write_n(memory_write_n), .address_enable_n(address_enable_n),
    .data_bus_out(dbo[2]), .data_bus_out_valid(dbv[2]), .mapped_address(ma2),
    .mapped_hit(mh[2]), .ready(rdy[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  int m_en   [NDUT][4];
  int m_page [NDUT][4];
  int waitc  [NDUT];
  int exp_hit  [NDUT];
  int exp_addr [NDUT];
  int prev_iow;
  int prev_mr;
  int prev_mw;

  int checks = 0;
  int errors = 0;
  int low_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic int io_base_of(input logic [1:0] s);
    case (s)
      2'd0:    return 'h208;
      2'd1:    return 'h218;
      2'd2:    return 'h258;
      default: return 'h268;
    endcase
  endfunction

  function automatic int frame_nib_of(input logic [1:0] s);
    case (s)
      2'd0:    return 'hC;
      2'd1:    return 'hD;
      2'd2:    return 'hE;
      default: return 'hA;
    endcase
  endfunction

  function automatic bit port_hit_m(input int d);
    int a16;
    int base;
    a16  = int'(address[15:0]);
    base = io_base_of(io_base_select);
    return enable && address_enable_n && (address[19:16] == 4'h0)
           && a16 >= base && a16 < base + NP[d];
  endfunction

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_update();
    bit wr_edge;
    bit mem_edge;
    if (reset) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int i = 0; i < 4; i++) begin
          m_en[d][i]   = 0;
          m_page[d][i] = 0;
        end
        waitc[d]    = 0;
        exp_hit[d]  = 0;
        exp_addr[d] = 0;
      end
    end else begin
      wr_edge  = prev_iow != 0 && !io_write_n;
      mem_edge = (prev_mr != 0 && !memory_read_n) || (prev_mw != 0 && !memory_write_n);
      for (int d = 0; d < NDUT; d++) begin
        int win;
        int idx;
        int e;
        bit hitc;
        win  = int'(address[15:14]);
        idx  = win % NP[d];
        hitc = enable && int'(address[19:16]) == frame_nib_of(frame_select)
               && win < NP[d] && m_en[d][idx] != 0;
        exp_hit[d]  = hitc;
        exp_addr[d] = m_page[d][idx] * 16384 + int'(address[13:0]);
        if (mem_edge && hitc) waitc[d] = WS[d];
        else if (waitc[d] > 0) waitc[d] = waitc[d] - 1;
        if (wr_edge && port_hit_m(d)) begin
          e = int'(address[15:0]) - io_base_of(io_base_select);
          m_en[d][e]   = int'(internal_data_bus[7]);
          m_page[d][e] = int'(internal_data_bus) % (1 << PB[d]);
        end
      end
    end
    prev_iow = reset ? 1 : int'(io_write_n);
    prev_mr  = reset ? 1 : int'(memory_read_n);
    prev_mw  = reset ? 1 : int'(memory_write_n);
  endtask

  // One clock: readback checked before the edge, registered outputs checked after it.
  task automatic step();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      bit v;
      int want;
      int e;
      v    = port_hit_m(d) && !io_read_n;
      want = 0;
      if (v) begin
        e    = int'(address[15:0]) - io_base_of(io_base_select);
        want = m_en[d][e] * 128 + m_page[d][e];
      end
      check($sformatf("rb_vld%0d", d), 32'(dbv[d]), 32'(v));
      check($sformatf("rb_dat%0d", d), 32'(dbo[d]), want);
    end
    @(posedge clock);
    model_update();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("hit%0d", d), 32'(mh[d]), exp_hit[d]);
      check($sformatf("maddr%0d", d), ma_w[d], exp_addr[d]);
      check($sformatf("ready%0d", d), 32'(rdy[d]), 32'(waitc[d] == 0));
    end
  endtask

  task automatic idle();
    io_read_n      = 1'b1;
    io_write_n     = 1'b1;
    memory_read_n  = 1'b1;
    memory_write_n = 1'b1;
  endtask

  task automatic io_write(input logic [19:0] a, input logic [7:0] dat);
    address           = a;
    internal_data_bus = dat;
    io_write_n        = 1'b1;
    step();
    io_write_n = 1'b0;
    step();
    io_write_n = 1'b1;
    step();
  endtask

  task automatic io_read(input logic [19:0] a);
    address   = a;
    io_read_n = 1'b0;
    step();
  endtask

  task automatic mem_read(input logic [19:0] a);
    address       = a;
    memory_read_n = 1'b1;
    step();
    memory_read_n = 1'b0;
    step();
  endtask

  initial begin
    reset             = 1'b1;
    enable            = 1'b1;
    io_base_select    = 2'd0;
    frame_select      = 2'd1;
    address           = 20'h0;
    internal_data_bus = 8'h00;
    address_enable_n  = 1'b1;
    idle();
    repeat (2) begin
      @(posedge clock);
      model_update();
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_hit%0d", d), 32'(mh[d]), 0);
      check($sformatf("rst_addr%0d", d), ma_w[d], 0);
      check($sformatf("rst_ready%0d", d), 32'(rdy[d]), 1);
    end
    reset = 1'b0;

    // Program entry 1 and translate through it.
    io_write(20'h00209, 8'h85);
    io_read(20'h00209);
    check("rb_85", 32'(dbo[0]), 32'h85);
    io_read_n = 1'b1;
    mem_read(20'hD4123);
    check("hit_d4123", 32'(mh[0]), 1);
    check("addr_d4123", ma_w[0], 32'h14123);
    idle();

    // Disabled entry and never-programmed entry both miss.
    io_write(20'h00209, 8'h05);
    mem_read(20'hD4000);
    check("hit_dis_entry", 32'(mh[0]), 0);
    idle();
    mem_read(20'hD0000);
    check("hit_reset_entry", 32'(mh[0]), 0);
    idle();

    // Held write strobe commits only the first-cycle data.
    address           = 20'h0020A;
    internal_data_bus = 8'h91;
    step();
    io_write_n = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      internal_data_bus = 8'($urandom);
      step();
    end
    io_write_n = 1'b1;
    step();
    io_read(20'h0020A);
    check("hold_wr", 32'(dbo[0]), 32'h91);
    io_read_n = 1'b1;

    // DMA cycles never write.
    address_enable_n = 1'b0;
    io_write(20'h0020A, 8'h33);
    address_enable_n = 1'b1;
    io_read(20'h0020A);
    check("dma_wr", 32'(dbo[0]), 32'h91);
    io_read_n = 1'b1;

    // Global disable hides everything but keeps contents.
    enable  = 1'b0;
    address = 20'hD8123;
    step();
    check("hit_off", 32'(mh[0]), 0);
    io_read(20'h0020A);
    check("rbv_off", 32'(dbv[0]), 0);
    io_read_n = 1'b1;
    enable    = 1'b1;
    address   = 20'hD8123;
    step();
    check("hit_on", 32'(mh[0]), 1);
    check("addr_on", ma_w[0], 32'h44123);
    io_read(20'h0020A);
    check("rb_on", 32'(dbo[0]), 32'h91);
    io_read_n = 1'b1;

    // Wait states: exactly three low clocks after a mapped read strobe.
    address = 20'hD8123;
    idle();
    repeat (4) step();
    memory_read_n = 1'b0;
    step();
    low_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      if (rdy[0] == 1'b0) low_cycles++;
      step();
    end
    check("wait_len", low_cycles, 3);

    // Reset during the second wait cycle.
    idle();
    step();
    memory_read_n = 1'b0;
    step();
    step();
    check("rdy_mid", 32'(rdy[0]), 0);
    reset = 1'b1;
    step();
    check("rdy_rst", 32'(rdy[0]), 1);
    reset = 1'b0;
    idle();
    io_read(20'h0020A);
    check("rb_clr_vld", 32'(dbv[0]), 1);
    check("rb_clr", 32'(dbo[0]), 0);
    io_read_n = 1'b1;

    // Two-window configuration: window 2 lies outside, page wraps to 5 bits.
    frame_select = 2'd2;
    io_write(20'h00208, 8'h83);
    io_write(20'h00209, 8'hFF);
    io_read(20'h00209);
    check("rb_9f", 32'(dbo[1]), 32'h9F);
    io_read_n = 1'b1;
    address   = 20'hE8000;
    step();
    check("hit_e8000", 32'(mh[1]), 0);
    address = 20'hE4000;
    step();
    check("hit_e4000", 32'(mh[1]), 1);
    check("addr_e4000", ma_w[1], 32'h7C000);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        io_base_select = 2'($urandom);
        frame_select   = 2'($urandom);
      end
      reset            = ($urandom_range(0, 199) == 0);
      enable           = ($urandom_range(0, 15) != 0);
      address_enable_n = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 3))
        0: address = {(($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0),
                      16'(io_base_of(io_base_select) + int'($urandom_range(0, 5)))};
        1, 2: address = {4'(frame_nib_of(frame_select)), 16'($urandom)};
        default: address = 20'($urandom);
      endcase
      internal_data_bus = 8'($urandom);
      io_write_n        = ($urandom_range(0, 2) != 0);
      io_read_n         = 1'($urandom);
      memory_read_n     = ($urandom_range(0, 2) != 0);
      memory_write_n    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
